// File: rtl/zmips_pkg.sv
// zmips shared definitions: register-file geometry, PC alias
// register numbers and the register-file write request bundle.
package zmips_pkg;

    localparam int REG_AW        = 5;
    localparam int DATA_W        = 32;
    localparam int REG_PC_SHADOW = 30;
    localparam int REG_PC_LIVE   = 31;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // r30/r31 alias the PC and must never reach the register file
    function automatic logic is_pc_alias(input logic [REG_AW-1:0] a);
        return (a == REG_AW'(REG_PC_SHADOW)) ||
               (a == REG_AW'(REG_PC_LIVE));
    endfunction

endpackage

// File: rtl/zmips_rr_arb.sv
// zmips_rr_arb: NREQ-way round-robin grant generator with pointer.
// Ports: clk, rst_n, valid (requests) -> grant (one-hot), grant_idx.
module zmips_rr_arb #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  valid,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last_grant;
    logic             any;

    // Search starts one past the last winner and wraps around,
    // so the last winner itself is checked last.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // Every grant is a transfer: grant is only given to a valid
    // requester, and the write port never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NREQ - 1);
        end else if (any) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/zmips_rf_wr_arb.sv
// zmips_rf_wr_arb: arbitrates NREQ register-file writers onto one
// registered write port, drops PC-alias writes and forwards in-flight data.
// Ports: req_valid/req_addr/req_data -> req_ready (one-hot grant);
//        wr/wr_addr/wr_data register-file write; rd_addr_0/1 -> fwd_hit_0/1,
//        fwd_data; drop_err pulse and saturating drop_cnt.
module zmips_rf_wr_arb
    import zmips_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0][REG_AW-1:0]  req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         wr,
    output logic [REG_AW-1:0]            wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    input  logic [REG_AW-1:0]            rd_addr_0,
    input  logic [REG_AW-1:0]            rd_addr_1,
    output logic                         fwd_hit_0,
    output logic                         fwd_hit_1,
    output logic [DATA_W-1:0]            fwd_data,
    output logic                         drop_err,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    wr_req_t          sel;
    logic             xfer;
    logic             drop;

    zmips_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // No handshake is offered while reset is held.
    assign req_ready = rst_n ? grant : '0;

    always_comb begin
        sel.addr = req_addr[grant_idx];
        sel.data = req_data[grant_idx];
    end

    assign xfer = |req_ready;
    assign drop = is_pc_alias(sel.addr);

    // wr_addr/wr_data only move on a real write so forwarding
    // always sees the last committed destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr       <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            drop_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wr       <= xfer && !drop;
            drop_err <= xfer && drop;
            if (xfer && !drop) begin
                wr_addr <= sel.addr;
                wr_data <= sel.data;
            end
            if (xfer && drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    assign fwd_hit_0 = wr && (rd_addr_0 == wr_addr);
    assign fwd_hit_1 = wr && (rd_addr_1 == wr_addr);
    assign fwd_data  = wr_data;

endmodule

// File: tb/tb_zmips_rf_wr_arb.sv
// tb_zmips_rf_wr_arb: table-driven bench for zmips_rf_wr_arb
// plus directed sequences for saturation and mid-operation reset.
module tb_zmips_rf_wr_arb;

    logic             clk;
    logic             rst_n;
    logic [2:0]       req_valid;
    logic [2:0][4:0]  req_addr;
    logic [2:0][31:0] req_data;
    logic [2:0]       req_ready;
    logic             wr;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [4:0]       rd_addr_0;
    logic [4:0]       rd_addr_1;
    logic             fwd_hit_0;
    logic             fwd_hit_1;
    logic [31:0]      fwd_data;
    logic             drop_err;
    logic [7:0]       drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic watch3 = 1'b0;
    int   seen3  = 0;

    zmips_rf_wr_arb #(
        .NREQ  (3),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_0 (rd_addr_0),
        .rd_addr_1 (rd_addr_1),
        .fwd_hit_0 (fwd_hit_0),
        .fwd_hit_1 (fwd_hit_1),
        .fwd_data  (fwd_data),
        .drop_err  (drop_err),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch3 && wr && wr_addr == 5'd3) begin
            seen3 = seen3 + 1;
        end
    end

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [4:0]  r0, r1;
        logic [2:0]  rdy;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        drop;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(
        input logic [2:0] v, input logic [4:0] a0, a1, a2,
        input logic [31:0] d0, d1, d2, input logic [4:0] r0, r1,
        input logic [2:0] rdy, input logic w, input logic [4:0] wa,
        input logic [31:0] wd, input logic drop, input logic [7:0] cnt);
        vec_t t;
        t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.r0 = r0; t.r1 = r1;
        t.rdy = rdy; t.wr = w; t.wa = wa; t.wd = wd;
        t.drop = drop; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2);
        req_valid   = v;
        req_addr[0] = a0; req_addr[1] = a1; req_addr[2] = a2;
        req_data[0] = d0; req_data[1] = d1; req_data[2] = d2;
    endtask

    initial begin
        logic [7:0] prev_cnt;
        int wr_seen;
        int wraps;
        int drops;

        tbl[0]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        tbl[1]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 0, 0, 3'b010, 1, 1, 'h100, 0, 0);
        tbl[2]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 0, 0, 3'b100, 1, 2, 'h200, 0, 0);
        tbl[3]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 0, 0, 3'b001, 1, 3, 'h300, 0, 0);
        tbl[4]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 0, 0, 3'b010, 1, 1, 'h100, 0, 0);
        tbl[5]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 0, 0, 3'b100, 1, 2, 'h200, 0, 0);
        tbl[6]  = mk(3'b010, 0, 5, 0, 0, 'hDEADBEEF, 0, 0, 0, 3'b010, 1, 3, 'h300, 0, 0);
        tbl[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 5, 5, 3'b000, 1, 5, 'hDEADBEEF, 0, 0);
        tbl[8]  = mk(3'b001, 31, 0, 0, 'h31, 0, 0, 0, 0, 3'b001, 0, 5, 'hDEADBEEF, 0, 0);
        tbl[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5, 'hDEADBEEF, 1, 1);
        tbl[10] = mk(3'b001, 7, 0, 0, 'h77, 0, 0, 0, 0, 3'b001, 0, 5, 'hDEADBEEF, 0, 1);
        tbl[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 7, 8, 3'b000, 1, 7, 'h77, 0, 1);
        tbl[12] = mk(3'b100, 0, 0, 9, 0, 0, 'h99, 0, 0, 3'b100, 0, 7, 'h77, 0, 1);
        tbl[13] = mk(3'b100, 0, 0, 9, 0, 0, 'h99, 0, 0, 3'b100, 1, 9, 'h99, 0, 1);
        tbl[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 9, 'h99, 0, 1);
        tbl[15] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 9, 'h99, 0, 1);
        tbl[16] = mk(3'b011, 10, 11, 0, 'hA, 'hB, 0, 0, 0, 3'b001, 0, 9, 'h99, 0, 1);
        tbl[17] = mk(3'b011, 10, 11, 0, 'hA, 'hB, 0, 0, 0, 3'b010, 1, 10, 'hA, 0, 1);
        tbl[18] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 11, 'hB, 0, 1);

        // reset state, with every requester asking
        rst_n = 1'b0;
        rd_addr_0 = '0;
        rd_addr_1 = '0;
        drive(3'b111, 1, 2, 3, 'h100, 'h200, 'h300);
        #12;
        chk("rst_ready", -1, 32'(req_ready), 0);
        chk("rst_wr", -1, 32'(wr), 0);
        chk("rst_wr_addr", -1, 32'(wr_addr), 0);
        chk("rst_wr_data", -1, wr_data, 0);
        chk("rst_drop_err", -1, 32'(drop_err), 0);
        chk("rst_drop_cnt", -1, 32'(drop_cnt), 0);
        #4;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
                  tbl[i].d0, tbl[i].d1, tbl[i].d2);
            rd_addr_0 = tbl[i].r0;
            rd_addr_1 = tbl[i].r1;
            @(negedge clk);
            chk("ready", i, 32'(req_ready), 32'(tbl[i].rdy));
            chk("wr", i, 32'(wr), 32'(tbl[i].wr));
            chk("wr_addr", i, 32'(wr_addr), 32'(tbl[i].wa));
            chk("wr_data", i, wr_data, tbl[i].wd);
            chk("drop_err", i, 32'(drop_err), 32'(tbl[i].drop));
            chk("drop_cnt", i, 32'(drop_cnt), 32'(tbl[i].cnt));
            chk("fwd_hit_0", i, 32'(fwd_hit_0),
                32'(tbl[i].wr && tbl[i].r0 == tbl[i].wa));
            chk("fwd_hit_1", i, 32'(fwd_hit_1),
                32'(tbl[i].wr && tbl[i].r1 == tbl[i].wa));
            chk("fwd_data", i, fwd_data, tbl[i].wd);
            @(posedge clk);
            #1;
        end

        // 300 back-to-back PC-alias writes: counter starts at 1
        wr_seen  = 0;
        wraps    = 0;
        drops    = 0;
        prev_cnt = drop_cnt;
        rd_addr_0 = '0;
        rd_addr_1 = '0;
        for (int i = 0; i < 300; i++) begin
            drive(3'b001, 30, 0, 0, 'h30, 0, 0);
            @(negedge clk);
            if (wr) wr_seen = wr_seen + 1;
            if (drop_cnt < prev_cnt) wraps = wraps + 1;
            if (drop_err) drops = drops + 1;
            prev_cnt = drop_cnt;
            @(posedge clk);
            #1;
        end
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_cnt", 300, 32'(drop_cnt), 255);
        chk("sat_drop_err", 300, 32'(drop_err), 1);
        chk("sat_no_wr", 300, wr_seen, 0);
        chk("sat_no_wrap", 300, wraps, 0);
        chk("sat_err_pulses", 300, drops, 299);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat_cnt_hold", 301, 32'(drop_cnt), 255);
        chk("sat_drop_idle", 301, 32'(drop_err), 0);
        @(posedge clk);
        #1;

        // reset right after a grant to addr 3 cancels that write
        watch3 = 1'b1;
        drive(3'b001, 3, 0, 0, 'h33, 0, 0);
        @(negedge clk);
        chk("pre_rst_ready", 400, 32'(req_ready), 32'(3'b001));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst_wr", 401, 32'(wr), 0);
        chk("midrst_wr_addr", 401, 32'(wr_addr), 0);
        chk("midrst_drop_cnt", 401, 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(3'b111, 1, 2, 4, 'h11, 'h22, 'h44);
        @(negedge clk);
        chk("post_rst_ready", 402, 32'(req_ready), 32'(3'b001));
        chk("post_rst_wr", 402, 32'(wr), 0);
        @(posedge clk);
        #1;
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_wr1", 403, 32'(wr), 1);
        chk("post_rst_addr", 403, 32'(wr_addr), 1);
        chk("post_rst_data", 403, wr_data, 'h11);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("no_wr_addr3", 404, seen3, 0);
        watch3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zmips_rf_wr_arb.md
ZMIPS_RF_WR_ARB -- requirements
Module: zmips_rf_wr_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning the number of write requesters (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the dropped-write counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ, per-requester write request.
REQ-006 The block SHALL have port req_addr, input, NREQ x 5, per-requester destination register.
REQ-007 The block SHALL have port req_data, input, NREQ x 32, per-requester write data.
REQ-008 The block SHALL have port req_ready, output, NREQ, one-hot grant; a transfer occurs when valid and ready are both high.
REQ-009 The block SHALL have ports wr (output, 1), wr_addr (output, 5) and wr_data (output, 32), which drive the register-file write port.
REQ-010 The block SHALL have ports rd_addr_0 and rd_addr_1, input, 5 each, which are copies of the register-file read addresses.
REQ-011 The block SHALL have ports fwd_hit_0 and fwd_hit_1 (output, 1 each) and fwd_data (output, 32), which carry forwarding of the in-flight write.
REQ-012 The block SHALL have port drop_err, output, 1, a one-cycle pulse when a write to r30/r31 is discarded.
REQ-013 The block SHALL have port drop_cnt, output, CNT_W, a saturating count of discarded writes.

Function
REQ-014 req_ready SHALL be combinational from req_valid and the round-robin pointer: at most one bit high, never high for a requester whose valid is low.
REQ-015 Arbitration SHALL be round-robin: the search starts at index (last_grant+1) mod NREQ and grants the first valid requester.
REQ-016 last_grant SHALL update to the granted index only on a cycle with a transfer; it SHALL hold when no request is valid.
REQ-017 A transfer with req_addr < 30 SHALL appear on wr/wr_addr/wr_data exactly one cycle later, registered; wr SHALL be high for exactly that one cycle.
REQ-018 A transfer with req_addr 30 or 31 (PC aliases) SHALL be accepted (ready high), SHALL NOT assert wr, SHALL pulse drop_err the next cycle and SHALL increment drop_cnt.
REQ-019 drop_cnt SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-020 The write port SHALL always be treated as accepting; the block SHALL sustain one write per cycle with no bubbles under continuous requests.
REQ-021 fwd_hit_n SHALL be (wr && rd_addr_n == wr_addr), combinational; fwd_data SHALL equal wr_data.
REQ-022 With a single valid requester, that requester SHALL be granted every cycle regardless of pointer position.
REQ-023 A requester that drops valid before a grant SHALL lose nothing; no request state is stored inside the block.

Reset
REQ-024 While rst_n is low, wr, drop_err and req_ready SHALL be 0, wr_addr SHALL be 0, wr_data SHALL be 0 and drop_cnt SHALL be 0.
REQ-025 Reset SHALL set last_grant to NREQ-1, so requester 0 has first priority.
REQ-026 Reset asserted mid-operation SHALL immediately cancel any pending registered write; the write SHALL NOT be issued after reset release.
REQ-027 The first grant SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package zmips_pkg SHALL hold the constants REG_PC_SHADOW=30, REG_PC_LIVE=31, the register address width 5, the data width 32, and a wr_req_t struct {addr, data}.
REQ-029 The block SHALL contain one sub-module, zmips_rr_arb (a generic NREQ round-robin grant generator with pointer); the output register, drop logic and forwarding SHALL live in the top.

Verification
REQ-030 A bench SHALL cover: reqs 0,1,2 all valid continuously for 6 cycles after reset -> grants 0,1,2,0,1,2, with wr high on every cycle from cycle 2.
REQ-031 A bench SHALL cover: only req 1 valid with addr 5, data 0xDEADBEEF -> ready[1] high, and next cycle wr=1, wr_addr=5, wr_data=0xDEADBEEF.
REQ-032 A bench SHALL cover: req 0 writes addr 31 -> ready[0] high, and next cycle wr=0, drop_err=1, drop_cnt=1.
REQ-033 A bench SHALL cover: 300 consecutive addr-30 writes with CNT_W=8 -> drop_cnt stops at 255.
REQ-034 A bench SHALL cover: write addr 7 in flight with rd_addr_0=7 and rd_addr_1=8 -> fwd_hit_0=1, fwd_hit_1=0, fwd_data=wr_data.
REQ-035 A bench SHALL cover: rst_n low in the cycle after a grant to addr 3 -> no wr pulse ever seen for addr 3, and after release req 0 has priority.
